// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver: enable codes,
// active-low segment patterns, FSM state and the displayed-word payload.
package seg_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned SLOT_W     = 2;

    // Active-low digit enables, one slot lit at a time
    localparam logic [NUM_DIGITS-1:0] EN_D0  = 3'b110;
    localparam logic [NUM_DIGITS-1:0] EN_D1  = 3'b101;
    localparam logic [NUM_DIGITS-1:0] EN_D2  = 3'b011;
    localparam logic [NUM_DIGITS-1:0] EN_OFF = 3'b111;

    // Active-low patterns, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK,
        SCAN
    } state_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0]         dp;
        logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    } disp_word_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Valid/ready handshake carrying a 3-digit BCD word plus decimal points.
interface seg_scan_driver_if;
    import seg_pkg::*;

    logic [NUM_DIGITS*DIGIT_W-1:0] i_digits;
    logic [NUM_DIGITS-1:0]         i_dp;
    logic                          i_valid;
    logic                          o_ready;

    modport master (output i_digits, output i_dp, output i_valid, input o_ready);
    modport slave  (input i_digits, input i_dp, input i_valid, output o_ready);

endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Nibble to active-low seven-segment pattern; non-decimal values show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [6:0]         pattern_c
);

    always_comb begin
        pattern_c = SEG_DASH;
        case (bcd)
            4'd0:    pattern_c = SEG_0;
            4'd1:    pattern_c = SEG_1;
            4'd2:    pattern_c = SEG_2;
            4'd3:    pattern_c = SEG_3;
            4'd4:    pattern_c = SEG_4;
            4'd5:    pattern_c = SEG_5;
            4'd6:    pattern_c = SEG_6;
            4'd7:    pattern_c = SEG_7;
            4'd8:    pattern_c = SEG_8;
            4'd9:    pattern_c = SEG_9;
            default: pattern_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit common-anode display driver with frame-boundary shadowing.
// Define SEG_LZB_EN to enable leading-zero blanking of digits 2 and 1.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seg_scan_driver_if.slave      bus,
    output logic [SLOT_W-1:0]     o_refresh_counter,
    output logic [NUM_DIGITS-1:0] o_segmentEnable,
    output logic [7:0]            o_segments,
    output logic                  o_frame_start
);

    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
    localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRESC_W-1:0]    presc_q, presc_d;
    state_t                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    disp_word_t            disp_q, disp_d;
    disp_word_t            pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ready_q, ready_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_q, frame_d;

    logic                  tick_c;
    logic                  boundary_c;
    logic                  accept_c;
    logic [DIGIT_W-1:0]    digit_c;
    logic                  dp_c;
    logic                  blank_c;
    logic [6:0]            pattern_c;

    // Prescaler, scan FSM, shadow transfer and handshake next-state
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        frame_d     = 1'b0;

        tick_c     = (presc_q == PRESC_W'(DIV - 1));
        presc_d    = tick_c ? '0 : presc_q + PRESC_W'(1);
        boundary_c = tick_c && (state_q == SCAN) && (slot_q == 2'd2);
        accept_c   = bus.i_valid && ready_q;

        case (state_q)
            BLANK: begin
                if (tick_c) begin
                    state_d = SCAN;
                    slot_d  = '0;
                    frame_d = 1'b1;
                end
            end
            SCAN: begin
                if (tick_c) begin
                    slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                end
                if (boundary_c) begin
                    frame_d = 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase

        if (boundary_c && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        // Acceptance on the boundary cycle lands in pending, shown one frame later
        if (accept_c) begin
            pend_d      = disp_word_t'{dp: bus.i_dp, digits: bus.i_digits};
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

    // Digit mux uses next slot and next displayed word so outputs move together
    always_comb begin
        digit_c = disp_d.digits[3:0];
        dp_c    = disp_d.dp[0];
        case (slot_d)
            2'd1: begin
                digit_c = disp_d.digits[7:4];
                dp_c    = disp_d.dp[1];
            end
            2'd2: begin
                digit_c = disp_d.digits[11:8];
                dp_c    = disp_d.dp[2];
            end
            default: begin
                digit_c = disp_d.digits[3:0];
                dp_c    = disp_d.dp[0];
            end
        endcase
        blank_c = 1'b0;
`ifdef SEG_LZB_EN
        if (slot_d == 2'd2) begin
            blank_c = (disp_d.digits[11:8] == 4'd0);
        end else if (slot_d == 2'd1) begin
            blank_c = (disp_d.digits[11:4] == 8'd0);
        end
`endif
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd       (digit_c),
        .pattern_c (pattern_c)
    );

    always_comb begin
        en_d  = EN_OFF;
        seg_d = 8'hFF;
        if (state_d == SCAN) begin
            case (slot_d)
                2'd0:    en_d = EN_D0;
                2'd1:    en_d = EN_D1;
                2'd2:    en_d = EN_D2;
                default: en_d = EN_OFF;
            endcase
            seg_d = {~dp_c, blank_c ? SEG_BLANK : pattern_c};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q     <= '0;
            state_q     <= BLANK;
            slot_q      <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            en_q        <= EN_OFF;
            seg_q       <= 8'hFF;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            state_q     <= state_d;
            slot_q      <= slot_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            en_q        <= en_d;
            seg_q       <= seg_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.o_ready       = ready_q;
    assign o_refresh_counter = slot_q;
    assign o_segmentEnable   = en_q;
    assign o_segments        = seg_q;
    assign o_frame_start     = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at DIV=4 (CLK_HZ=100, SCAN_HZ=25).
module tb_seg_scan_driver;

`ifdef SEG_LZB_EN
    localparam logic [7:0] LZ0 = 8'hFF;
`else
    localparam logic [7:0] LZ0 = 8'hC0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] refresh_counter;
    logic [2:0] segment_enable;
    logic [7:0] segments;
    logic       frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int gap;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .CLK_HZ  (100),
        .SCAN_HZ (25)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .bus               (bus),
        .o_refresh_counter (refresh_counter),
        .o_segmentEnable   (segment_enable),
        .o_segments        (segments),
        .o_frame_start     (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 40);
        chk("frame_seen", 32'(frame_start), 32'd1);
    endtask

    task automatic load(input logic [11:0] d, input logic [2:0] p);
        bus.i_digits = d;
        bus.i_dp     = p;
        bus.i_valid  = 1'b1;
        step();
        bus.i_valid  = 1'b0;
    endtask

    // Entered on the first cycle of slot 0; leaves on the first cycle of slot 2
    task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        chk("f_en0",   32'(segment_enable), 32'(3'b110));
        chk("f_slot0", 32'(refresh_counter), 32'd0);
        chk("f_seg0",  32'(segments), 32'(s0));
        repeat (4) step();
        chk("f_en1",   32'(segment_enable), 32'(3'b101));
        chk("f_slot1", 32'(refresh_counter), 32'd1);
        chk("f_seg1",  32'(segments), 32'(s1));
        repeat (4) step();
        chk("f_en2",   32'(segment_enable), 32'(3'b011));
        chk("f_slot2", 32'(refresh_counter), 32'd2);
        chk("f_seg2",  32'(segments), 32'(s2));
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_digits = '0;
        bus.i_dp     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en",    32'(segment_enable), 32'(3'b111));
        chk("rst_seg",   32'(segments), 32'hFF);
        chk("rst_slot",  32'(refresh_counter), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_frame", 32'(frame_start), 32'd0);
        rst = 1'b0;

        // BLANK for the first prescaler period, then slots of 4 cycles
        step();
        chk("blank_en",  32'(segment_enable), 32'(3'b111));
        chk("blank_seg", 32'(segments), 32'hFF);
        step();
        step();
        chk("blank_en_last", 32'(segment_enable), 32'(3'b111));
        step();
        chk("first_en",    32'(segment_enable), 32'(3'b110));
        chk("first_slot",  32'(refresh_counter), 32'd0);
        chk("first_frame", 32'(frame_start), 32'd1);
        chk("first_seg",   32'(segments), 32'hC0);
        step();
        chk("frame_pulse_end", 32'(frame_start), 32'd0);
        chk("slot0_hold",      32'(segment_enable), 32'(3'b110));
        repeat (3) step();
        chk("slot1_en",  32'(segment_enable), 32'(3'b101));
        chk("slot1_seg", 32'(segments), 32'(LZ0));
        repeat (4) step();
        chk("slot2_en",  32'(segment_enable), 32'(3'b011));
        repeat (4) step();
        chk("frame2_pulse", 32'(frame_start), 32'd1);
        chk("frame2_slot",  32'(refresh_counter), 32'd0);

        // Mid-frame load; a second word offered while not ready must be ignored
        chk("pre_load_ready", 32'(bus.o_ready), 32'd1);
        bus.i_digits = 12'h907;
        bus.i_dp     = 3'b010;
        bus.i_valid  = 1'b1;
        step();
        chk("busy_ready", 32'(bus.o_ready), 32'd0);
        bus.i_digits = 12'h111;
        bus.i_dp     = 3'b000;
        step();
        chk("busy_ready2", 32'(bus.o_ready), 32'd0);
        chk("not_early",   32'(segments), 32'hC0);
        wait_frame(gap);
        chk("load_gap",   32'(gap), 32'd10);
        chk("bnd_ready",  32'(bus.o_ready), 32'd1);
        chk("907_seg0",   32'(segments), 32'hF8);
        step();
        chk("111_accept", 32'(bus.o_ready), 32'd0);
        bus.i_valid = 1'b0;
        repeat (3) step();
        chk("907_en1",  32'(segment_enable), 32'(3'b101));
        chk("907_seg1", 32'(segments), 32'h40);
        repeat (4) step();
        chk("907_seg2", 32'(segments), 32'h90);
        wait_frame(gap);
        chk("frame_gap", 32'(gap), 32'd4);
        check_frame(8'hF9, 8'hF9, 8'hF9);

        // Leading zeros, then a non-decimal nibble
        load(12'h005, 3'b000);
        wait_frame(gap);
        check_frame(8'h92, LZ0, LZ0);
        load(12'h2C3, 3'b000);
        wait_frame(gap);
        check_frame(8'hB0, 8'hBF, 8'hA4);

        // Accept on the boundary cycle: old word still shown in the new frame
        repeat (3) step();
        load(12'h456, 3'b000);
        chk("bnd_acc_frame", 32'(frame_start), 32'd1);
        chk("bnd_acc_seg0",  32'(segments), 32'hB0);
        chk("bnd_acc_ready", 32'(bus.o_ready), 32'd0);
        wait_frame(gap);
        chk("bnd_acc_gap", 32'(gap), 32'd12);
        check_frame(8'h82, 8'h92, 8'h99);

        // Reset in slot 1 with pending full discards the pending word
        wait_frame(gap);
        repeat (4) step();
        load(12'h888, 3'b111);
        chk("pend_full", 32'(bus.o_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_en",    32'(segment_enable), 32'(3'b111));
        chk("mid_rst_seg",   32'(segments), 32'hFF);
        chk("mid_rst_slot",  32'(refresh_counter), 32'd0);
        chk("mid_rst_frame", 32'(frame_start), 32'd0);
        chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        wait_frame(gap);
        chk("rst_gap", 32'(gap), 32'd4);
        check_frame(8'hC0, LZ0, LZ0);
        wait_frame(gap);
        check_frame(8'hC0, LZ0, LZ0);
        chk("post_rst_ready", 32'(bus.o_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
